// File: rtl/dm_stage.sv
// M-stage data memory: byte-enable generation, lane-masked stores, and the M/W
// boundary registers feeding drext. Define DM_DISPLAY_EN to trace performed stores.
module dm_stage #(
   parameter int unsigned ADDR_WIDTH = 12
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic [31:0] pc,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        memwrite,
   input  logic        memread,
   input  logic [1:0]  width,
   input  logic        sign_in,
   output logic [31:0] DR,
   output logic [3:0]  BE,
   output logic        dmExt,
   output logic        align_err
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   logic [31:0]           mem [DEPTH];
   logic [ADDR_WIDTH-1:0] idx;
   logic [3:0]            be_c;
   logic                  mis_c;
   logic [31:0]           lane_c;
   logic [31:0]           rd_word;
   logic [31:0]           merged_word;
   logic                  we_c;
   logic                  unused_ok;

   assign idx       = addr[ADDR_WIDTH+1:2];
   assign rd_word   = mem[idx];
   assign we_c      = memwrite & ~stall & ~mis_c;
   // pc and the upper address bits only matter for the optional store trace
   assign unused_ok = ^{pc, addr[31:ADDR_WIDTH+2]};

   // Byte enables, misalignment and replicated store lanes
   always_comb begin
      be_c   = 4'b0000;
      mis_c  = 1'b0;
      lane_c = wdata;
      case (width)
         2'b00: begin
            if (addr[1:0] == 2'b00) be_c = 4'b1111;
            else                    mis_c = 1'b1;
         end
         2'b01: begin
            lane_c = {2{wdata[15:0]}};
            if (addr[1:0] == 2'b00)      be_c = 4'b0011;
            else if (addr[1:0] == 2'b10) be_c = 4'b1100;
            else                         mis_c = 1'b1;
         end
         2'b10: begin
            lane_c = {4{wdata[7:0]}};
            be_c   = 4'b0001 << addr[1:0];
         end
         default: mis_c = 1'b1;
      endcase
   end

   always_comb begin
      merged_word = rd_word;
      for (int k = 0; k < 4; k++) begin
         if (be_c[k]) merged_word[8*k +: 8] = lane_c[8*k +: 8];
      end
   end

   // RAM and M/W registers; reset wins over stall and over a concurrent store
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[ADDR_WIDTH'(i)] <= '0;
         DR        <= '0;
         BE        <= 4'b0000;
         dmExt     <= 1'b0;
         align_err <= 1'b0;
      end else begin
         if (we_c) begin
            mem[idx] <= merged_word;
`ifdef DM_DISPLAY_EN
            $display("%d@%h: *%h <= %h", $time, pc, {addr[31:2], 2'b00}, merged_word);
`endif
         end
         if (!stall) begin
            DR        <= rd_word;
            BE        <= (memread & ~memwrite) ? be_c : 4'b0000;
            dmExt     <= sign_in & memread;
            align_err <= mis_c & (memread | memwrite);
         end
      end
   end

endmodule

// File: tb/tb_dm_stage.sv
// Directed bench for dm_stage: a vector table of single-cycle accesses with
// hand-computed W-side results, plus stall and reset sequences.
module tb_dm_stage;

   logic        clk = 1'b0;
   logic        reset, stall, memwrite, memread, sign_in;
   logic [31:0] pc, addr, wdata;
   logic [1:0]  width;
   logic [31:0] DR;
   logic [3:0]  BE;
   logic        dmExt, align_err;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        rst;
      logic        stl;
      logic        mw;
      logic        mr;
      logic [1:0]  w;
      logic        sgn;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] e_dr;
      logic [3:0]  e_be;
      logic        e_ext;
      logic        e_err;
   } vec_t;

   vec_t tbl[$];

   dm_stage #(.ADDR_WIDTH(12)) dut (
      .clk(clk), .reset(reset), .stall(stall), .pc(pc), .addr(addr),
      .wdata(wdata), .memwrite(memwrite), .memread(memread), .width(width),
      .sign_in(sign_in), .DR(DR), .BE(BE), .dmExt(dmExt), .align_err(align_err)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic rst, input logic stl, input logic mw,
                               input logic mr, input logic [1:0] w, input logic sgn,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic [31:0] e_dr, input logic [3:0] e_be,
                               input logic e_ext, input logic e_err);
      vec_t v;
      v.rst = rst; v.stl = stl; v.mw = mw; v.mr = mr; v.w = w; v.sgn = sgn;
      v.a = a; v.d = d; v.e_dr = e_dr; v.e_be = e_be; v.e_ext = e_ext; v.e_err = e_err;
      return v;
   endfunction

   // Drive one vector, let one edge pass, compare all four outputs
   task automatic run(input string tag, input vec_t v);
      reset = v.rst; stall = v.stl; memwrite = v.mw; memread = v.mr;
      width = v.w; sign_in = v.sgn; addr = v.a; wdata = v.d; pc = pc + 32'd4;
      @(posedge clk);
      #1;
      total++;
      if (DR !== v.e_dr) begin
         bad++; $display("FAIL %s DR got %h exp %h", tag, DR, v.e_dr);
      end
      total++;
      if (BE !== v.e_be) begin
         bad++; $display("FAIL %s BE got %b exp %b", tag, BE, v.e_be);
      end
      total++;
      if (dmExt !== v.e_ext) begin
         bad++; $display("FAIL %s dmExt got %b exp %b", tag, dmExt, v.e_ext);
      end
      total++;
      if (align_err !== v.e_err) begin
         bad++; $display("FAIL %s align_err got %b exp %b", tag, align_err, v.e_err);
      end
   endtask

   initial begin
      pc = 32'h0040_0000;
      // rst stl mw mr width sgn addr wdata | DR BE ext err
      tbl.push_back(mk(1,0,0,0,2'b00,0,32'h00,32'h0,        32'h0,        4'h0,0,0)); // reset
      tbl.push_back(mk(0,0,1,0,2'b00,0,32'h10,32'h12345678, 32'h0,        4'h0,0,0)); // sw
      tbl.push_back(mk(0,0,0,1,2'b00,0,32'h10,32'h0,        32'h12345678, 4'hF,0,0)); // lw
      tbl.push_back(mk(0,0,1,0,2'b10,0,32'h12,32'hAB,       32'h12345678, 4'h0,0,0)); // sb, pre-write DR
      tbl.push_back(mk(0,0,0,1,2'b00,0,32'h10,32'h0,        32'h12AB5678, 4'hF,0,0));
      tbl.push_back(mk(0,0,1,0,2'b01,0,32'h10,32'hBEEF,     32'h12AB5678, 4'h0,0,0)); // sh
      tbl.push_back(mk(0,0,0,1,2'b00,0,32'h10,32'h0,        32'h12ABBEEF, 4'hF,0,0));
      tbl.push_back(mk(0,0,1,0,2'b00,0,32'h14,32'h80010000, 32'h0,        4'h0,0,0));
      tbl.push_back(mk(0,0,0,1,2'b01,1,32'h16,32'h0,        32'h80010000, 4'hC,1,0)); // lh hi
      tbl.push_back(mk(0,0,0,1,2'b10,0,32'h17,32'h0,        32'h80010000, 4'h8,0,0)); // lbu
      tbl.push_back(mk(0,0,0,1,2'b01,0,32'h14,32'h0,        32'h80010000, 4'h3,0,0)); // lhu lo
      tbl.push_back(mk(0,0,1,0,2'b00,0,32'h11,32'hDEADBEEF, 32'h12ABBEEF, 4'h0,0,1)); // misaligned sw
      tbl.push_back(mk(0,0,0,1,2'b00,0,32'h10,32'h0,        32'h12ABBEEF, 4'hF,0,0)); // unchanged
      tbl.push_back(mk(0,0,0,1,2'b01,0,32'h13,32'h0,        32'h12ABBEEF, 4'h0,0,1)); // lh odd
      tbl.push_back(mk(0,0,0,1,2'b11,0,32'h10,32'h0,        32'h12ABBEEF, 4'h0,0,1)); // width 11
      tbl.push_back(mk(0,0,0,1,2'b10,1,32'h11,32'h0,        32'h12ABBEEF, 4'h2,1,0)); // lb
      tbl.push_back(mk(0,0,1,1,2'b00,0,32'h18,32'hCAFEF00D, 32'h0,        4'h0,0,0)); // mr&mw = store
      tbl.push_back(mk(0,0,0,1,2'b00,0,32'h18,32'h0,        32'hCAFEF00D, 4'hF,0,0));
      tbl.push_back(mk(0,0,0,0,2'b11,0,32'h18,32'h0,        32'hCAFEF00D, 4'h0,0,0)); // no access
      foreach (tbl[i]) run($sformatf("vec%0d", i), tbl[i]);

      // stall holds outputs and suppresses the store; release lets it happen
      run("stl_pre",  mk(0,0,0,1,2'b00,0,32'h10,32'h0,        32'h12ABBEEF, 4'hF,0,0));
      run("stl_sw",   mk(0,1,1,0,2'b00,0,32'h20,32'hFFFFFFFF, 32'h12ABBEEF, 4'hF,0,0));
      run("stl_lw",   mk(0,1,0,1,2'b10,1,32'h21,32'h0,        32'h12ABBEEF, 4'hF,0,0));
      run("stl_rel",  mk(0,0,0,1,2'b00,0,32'h20,32'h0,        32'h0,        4'hF,0,0));
      run("stl_sw2",  mk(0,0,1,0,2'b00,0,32'h20,32'hFFFFFFFF, 32'h0,        4'h0,0,0));
      run("stl_chk",  mk(0,0,0,1,2'b00,0,32'h20,32'h0,        32'hFFFFFFFF, 4'hF,0,0));

      // reset clears RAM, drops a concurrent store, and beats stall
      run("rst_sw",   mk(0,0,1,0,2'b00,0,32'h00,32'h55,       32'h0,        4'h0,0,0));
      run("rst_lw",   mk(0,0,0,1,2'b00,0,32'h00,32'h0,        32'h55,       4'hF,0,0));
      run("rst_st",   mk(1,0,1,0,2'b00,0,32'h04,32'h77,       32'h0,        4'h0,0,0));
      run("rst_lw0",  mk(0,0,0,1,2'b00,0,32'h00,32'h0,        32'h0,        4'hF,0,0));
      run("rst_lw4",  mk(0,0,0,1,2'b00,0,32'h04,32'h0,        32'h0,        4'hF,0,0));
      run("rst_lw10", mk(0,0,0,1,2'b00,0,32'h10,32'h0,        32'h0,        4'hF,0,0));
      run("rs_sw",    mk(0,0,1,0,2'b00,0,32'h08,32'h99,       32'h0,        4'h0,0,0));
      run("rs_lw",    mk(0,0,0,1,2'b01,1,32'h0A,32'h0,        32'h99,       4'hC,1,0));
      run("rs_both",  mk(1,1,0,1,2'b00,1,32'h08,32'h0,        32'h0,        4'h0,0,0));
      run("rs_chk",   mk(0,0,0,1,2'b00,0,32'h08,32'h0,        32'h0,        4'hF,0,0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
